// File: rtl/hdc_seq_pkg.sv
// Shared types and default widths for the hypervector operation sequencer.
package hdc_seq_pkg;

  localparam int unsigned SEQ_OP_W   = 2;
  localparam int unsigned SEQ_ADDR_W = 21;
  localparam int unsigned SEQ_DATA_W = 32;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t DRAIN = 2'd2;

  typedef struct packed {
    logic [SEQ_OP_W-1:0]   op;
    logic [SEQ_ADDR_W-1:0] addr_a;
    logic [SEQ_ADDR_W-1:0] addr_b;
    logic [SEQ_ADDR_W-1:0] addr_c;
  } cmd_t;

endpackage

// File: rtl/hdc_cmd_fifo.sv
// Synchronous command queue; head is visible combinationally while non-empty.
module hdc_cmd_fifo
  import hdc_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  cmd_t                   i_data,
  input  logic                   i_pop,
  output cmd_t                   o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/hdc_op_sequencer.sv
// Queues kernel commands, runs one kernel at a time and owns the shared RAM port.
module hdc_op_sequencer
  import hdc_seq_pkg::*;
#(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned OP_W        = SEQ_OP_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ADDR_W      = SEQ_ADDR_W,
  parameter int unsigned DATA_W      = SEQ_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [OP_W-1:0]               cmd_op,
  input  logic [ADDR_W-1:0]             cmd_addr_a,
  input  logic [ADDR_W-1:0]             cmd_addr_b,
  input  logic [ADDR_W-1:0]             cmd_addr_c,
  output logic [NUM_ENGINES-1:0]        eng_valid,
  output logic [ADDR_W-1:0]             eng_addr_a,
  output logic [ADDR_W-1:0]             eng_addr_b,
  output logic [ADDR_W-1:0]             eng_addr_c,
  input  logic [NUM_ENGINES-1:0]        eng_done,
  input  logic [NUM_ENGINES-1:0]        eng_we_n,
  input  logic [NUM_ENGINES*ADDR_W-1:0] eng_waddress,
  input  logic [NUM_ENGINES*DATA_W-1:0] eng_data_wr,
  input  logic [NUM_ENGINES*ADDR_W-1:0] eng_raddress,
  output logic                          ram_we_n,
  output logic [ADDR_W-1:0]             ram_waddress,
  output logic [DATA_W-1:0]             ram_data_wr,
  output logic [ADDR_W-1:0]             ram_raddress,
  output logic                          busy,
  output logic                          cmp_valid,
  output logic [OP_W-1:0]               cmp_op,
  output logic                          err_badop
);

  localparam int unsigned NUM_OPS = 1 << OP_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t                 r_state;
  cmd_t                   r_cur;
  logic [NUM_ENGINES-1:0] r_eng_valid;
  logic                   r_cmp_valid;
  logic [OP_W-1:0]        r_cmp_op;
  logic                   r_err_badop;

  state_t                 w_state_nxt;
  cmd_t                   w_cur_nxt;
  logic [NUM_ENGINES-1:0] w_eng_valid_nxt;
  logic                   w_cmp_valid_nxt;
  logic [OP_W-1:0]        w_cmp_op_nxt;
  logic                   w_err_nxt;
  logic                   w_pop;

  cmd_t                   w_cmd_in;
  cmd_t                   w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [CNT_W-1:0]       w_count;
  logic                   w_push;
  logic                   w_done_sel;
  logic [NUM_OPS-1:0]     w_op_ok;

  assign w_cmd_in = '{op: cmd_op, addr_a: cmd_addr_a, addr_b: cmd_addr_b, addr_c: cmd_addr_c};
  assign w_push   = cmd_valid && cmd_ready;

  hdc_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign cmd_ready  = !w_full;
  assign busy       = (r_state != IDLE) || (w_count != '0);
  assign eng_valid  = r_eng_valid;
  assign eng_addr_a = r_cur.addr_a;
  assign eng_addr_b = r_cur.addr_b;
  assign eng_addr_c = r_cur.addr_c;
  assign cmp_valid  = r_cmp_valid;
  assign cmp_op     = r_cmp_op;
  assign err_badop  = r_err_badop;

  // Opcodes that map onto an attached kernel.
  always_comb begin
    w_op_ok = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      w_op_ok[i] = (i < NUM_ENGINES);
    end
  end

  // Only the running kernel reaches the RAM; everything else is parked.
  always_comb begin
    ram_we_n     = 1'b1;
    ram_waddress = '0;
    ram_data_wr  = '0;
    ram_raddress = '0;
    w_done_sel   = 1'b0;
    if (r_state == RUN) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (r_cur.op == OP_W'(i)) begin
          ram_we_n     = eng_we_n[i];
          ram_waddress = eng_waddress[i*ADDR_W +: ADDR_W];
          ram_data_wr  = eng_data_wr[i*DATA_W +: DATA_W];
          ram_raddress = eng_raddress[i*ADDR_W +: ADDR_W];
          w_done_sel   = eng_done[i];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur;
    w_eng_valid_nxt = '0;
    w_cmp_valid_nxt = 1'b0;
    w_cmp_op_nxt    = r_cmp_op;
    w_err_nxt       = 1'b0;
    w_pop           = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_cur_nxt = w_head;
          if (w_op_ok[w_head.op]) begin
            w_state_nxt     = RUN;
            w_eng_valid_nxt = NUM_ENGINES'(1) << w_head.op;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      RUN: begin
        w_eng_valid_nxt = r_eng_valid;
        if (w_done_sel) begin
          w_state_nxt     = DRAIN;
          w_eng_valid_nxt = '0;
          w_cmp_valid_nxt = 1'b1;
          w_cmp_op_nxt    = r_cur.op;
        end
      end
      DRAIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_eng_valid <= '0;
      r_cmp_valid <= 1'b0;
      r_cmp_op    <= '0;
      r_err_badop <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_eng_valid <= w_eng_valid_nxt;
      r_cmp_valid <= w_cmp_valid_nxt;
      r_cmp_op    <= w_cmp_op_nxt;
      r_err_badop <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_hdc_op_sequencer.sv
// Directed bench for hdc_op_sequencer: vector table plus multi-cycle sequences.
module tb_hdc_op_sequencer;

  localparam int AW = 21;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4-kernel instance
  logic          c_valid, c_ready;
  logic [1:0]    c_op;
  logic [AW-1:0] c_a, c_b, c_c;
  logic [3:0]    e_valid, e_done, e_we_n;
  logic [AW-1:0] e_aa, e_ab, e_ac;
  logic [4*AW-1:0] e_wa, e_ra;
  logic [4*DW-1:0] e_wd;
  logic          r_we_n, busy, cmp_valid, err;
  logic [AW-1:0] r_wa, r_ra;
  logic [DW-1:0] r_wd;
  logic [1:0]    cmp_op;

  // 3-kernel instance for the unmapped-opcode case
  logic          d3_valid, d3_ready;
  logic [1:0]    d3_op;
  logic [2:0]    d3_ev, d3_done, d3_we_n;
  logic [AW-1:0] d3_aa, d3_ab, d3_ac;
  logic [3*AW-1:0] d3_wa, d3_ra;
  logic [3*DW-1:0] d3_wd;
  logic          d3_rwe, d3_busy, d3_cmp, d3_err;
  logic [AW-1:0] d3_rwa, d3_rra;
  logic [DW-1:0] d3_rwd;
  logic [1:0]    d3_cop;

  hdc_op_sequencer #(.NUM_ENGINES(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(c_valid), .cmd_ready(c_ready), .cmd_op(c_op),
    .cmd_addr_a(c_a), .cmd_addr_b(c_b), .cmd_addr_c(c_c), .eng_valid(e_valid),
    .eng_addr_a(e_aa), .eng_addr_b(e_ab), .eng_addr_c(e_ac), .eng_done(e_done),
    .eng_we_n(e_we_n), .eng_waddress(e_wa), .eng_data_wr(e_wd), .eng_raddress(e_ra),
    .ram_we_n(r_we_n), .ram_waddress(r_wa), .ram_data_wr(r_wd), .ram_raddress(r_ra),
    .busy(busy), .cmp_valid(cmp_valid), .cmp_op(cmp_op), .err_badop(err)
  );

  hdc_op_sequencer #(.NUM_ENGINES(3)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(d3_valid), .cmd_ready(d3_ready), .cmd_op(d3_op),
    .cmd_addr_a(21'd0), .cmd_addr_b(21'd0), .cmd_addr_c(21'd0), .eng_valid(d3_ev),
    .eng_addr_a(d3_aa), .eng_addr_b(d3_ab), .eng_addr_c(d3_ac), .eng_done(d3_done),
    .eng_we_n(d3_we_n), .eng_waddress(d3_wa), .eng_data_wr(d3_wd), .eng_raddress(d3_ra),
    .ram_we_n(d3_rwe), .ram_waddress(d3_rwa), .ram_data_wr(d3_rwd), .ram_raddress(d3_rra),
    .busy(d3_busy), .cmp_valid(d3_cmp), .cmp_op(d3_cop), .err_badop(d3_err)
  );

  int errors = 0;
  int checks = 0;
  int n_d3_err = 0;
  int n_d3_cmp = 0;

  always @(negedge clk) begin
    if (d3_err) n_d3_err++;
    if (d3_cmp) n_d3_cmp++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          v;
    logic [1:0]    op;
    logic [AW-1:0] a, b, c;
    logic [3:0]    done;
    int            wk;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [3:0]    x_ev;
    logic [AW-1:0] x_ab;
    logic          x_we;
    logic [AW-1:0] x_wa;
    logic [DW-1:0] x_wd;
    logic          x_cv;
    logic [1:0]    x_cop;
    logic          x_busy;
    logic          x_rdy;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Kernel i idles with recognisable junk; kernel wk may override its write port.
  task automatic set_kernels(input int wk, input logic we, input logic [AW-1:0] wa,
                             input logic [DW-1:0] wd);
    for (int i = 0; i < 4; i++) begin
      e_we_n[i] = 1'b1;
      e_wa[i*AW +: AW] = AW'(100 + i);
      e_wd[i*DW +: DW] = DW'(200 + i);
      e_ra[i*AW +: AW] = AW'(300 + i);
    end
    if (wk >= 0) begin
      e_we_n[wk] = we;
      e_wa[wk*AW +: AW] = wa;
      e_wd[wk*DW +: DW] = wd;
    end
  endtask

  task automatic push(input logic [1:0] op, input logic [AW-1:0] b);
    c_valid = 1'b1;
    c_op = op;
    c_a = AW'(op);
    c_b = b;
    c_c = AW'(op) + AW'(16);
  endtask

  task automatic wait_dispatch(input string name, input logic [3:0] exp);
    int n;
    n = 0;
    while (e_valid == 4'b0 && n < 20) begin
      step();
      n++;
    end
    chk(name, e_valid, exp);
  endtask

  initial begin
    logic [1:0] qops [5];
    logic [3:0] oh;
    qops[0] = 2'd0; qops[1] = 2'd1; qops[2] = 2'd2; qops[3] = 2'd3; qops[4] = 2'd0;

    //            v  op  a   b      c      done  wk we  wa   wd     ev     ab      we  wa     wd     cv cop busy rdy
    tbl[0]  = '{1'b1, 2'd1, 21'd0, 21'd1024, 21'd2048, 4'b0000, -1, 1'b1, 21'd0, 32'd0,
                4'b0000, 21'd0, 1'b1, 21'd0, 32'd0, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0000, -1, 1'b1, 21'd0, 32'd0,
                4'b0010, 21'd1024, 1'b1, 21'd101, 32'd201, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0000, 1, 1'b0, 21'd2048, 32'd50,
                4'b0010, 21'd1024, 1'b0, 21'd2048, 32'd50, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0010, -1, 1'b1, 21'd0, 32'd0,
                4'b0000, 21'd1024, 1'b1, 21'd0, 32'd0, 1'b1, 2'd1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0010, -1, 1'b1, 21'd0, 32'd0,
                4'b0000, 21'd1024, 1'b1, 21'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0010, -1, 1'b1, 21'd0, 32'd0,
                4'b0000, 21'd1024, 1'b1, 21'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 2'd2, 21'd7, 21'd8, 21'd9, 4'b0000, -1, 1'b1, 21'd0, 32'd0,
                4'b0000, 21'd1024, 1'b1, 21'd0, 32'd0, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0000, -1, 1'b1, 21'd0, 32'd0,
                4'b0100, 21'd8, 1'b1, 21'd102, 32'd202, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0001, 0, 1'b0, 21'd5, 32'd99,
                4'b0100, 21'd8, 1'b1, 21'd102, 32'd202, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0001, 2, 1'b0, 21'd77, 32'd88,
                4'b0100, 21'd8, 1'b0, 21'd77, 32'd88, 1'b0, 2'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0100, -1, 1'b1, 21'd0, 32'd0,
                4'b0000, 21'd8, 1'b1, 21'd0, 32'd0, 1'b1, 2'd2, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 2'd0, 21'd0, 21'd0, 21'd0, 4'b0000, -1, 1'b1, 21'd0, 32'd0,
                4'b0000, 21'd8, 1'b1, 21'd0, 32'd0, 1'b0, 2'd0, 1'b0, 1'b1};

    reset = 1'b1;
    c_valid = 1'b0; c_op = '0; c_a = '0; c_b = '0; c_c = '0; e_done = '0;
    d3_valid = 1'b0; d3_op = '0; d3_done = '0; d3_we_n = '1; d3_wa = '0; d3_wd = '0; d3_ra = '0;
    set_kernels(-1, 1'b1, '0, '0);
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst cmd_ready", c_ready, 1);
    chk("rst eng_valid", e_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst ram_we_n", r_we_n, 1);
    chk("rst ram_waddress", r_wa, 0);
    chk("rst ram_data_wr", r_wd, 0);
    chk("rst ram_raddress", r_ra, 0);
    chk("rst cmp_valid", cmp_valid, 0);
    chk("rst cmp_op", cmp_op, 0);
    chk("rst err_badop", err, 0);
    chk("rst eng_addr_b", e_ab, 0);

    // Single command, done held into IDLE, and RAM isolation
    for (int i = 0; i < 12; i++) begin
      c_valid = tbl[i].v; c_op = tbl[i].op; c_a = tbl[i].a; c_b = tbl[i].b; c_c = tbl[i].c;
      e_done = tbl[i].done;
      set_kernels(tbl[i].wk, tbl[i].we, tbl[i].wa, tbl[i].wd);
      step();
      chk($sformatf("vec%0d eng_valid", i), e_valid, tbl[i].x_ev);
      chk($sformatf("vec%0d eng_addr_b", i), e_ab, tbl[i].x_ab);
      chk($sformatf("vec%0d ram_we_n", i), r_we_n, tbl[i].x_we);
      chk($sformatf("vec%0d ram_waddress", i), r_wa, tbl[i].x_wa);
      chk($sformatf("vec%0d ram_data_wr", i), r_wd, tbl[i].x_wd);
      chk($sformatf("vec%0d cmp_valid", i), cmp_valid, tbl[i].x_cv);
      if (tbl[i].x_cv) chk($sformatf("vec%0d cmp_op", i), cmp_op, tbl[i].x_cop);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].x_busy);
      chk($sformatf("vec%0d cmd_ready", i), c_ready, tbl[i].x_rdy);
      if (i == 2) begin
        chk("vec2 eng_addr_c", e_ac, 2048);
        chk("vec2 ram_raddress", r_ra, 301);
      end
    end
    c_valid = 1'b0;
    e_done = '0;
    set_kernels(-1, 1'b1, '0, '0);

    // Queue full: one in RUN, four queued, extra push dropped
    for (int j = 0; j < 5; j++) begin
      push(qops[j], AW'(j));
      step();
    end
    chk("full cmd_ready", c_ready, 0);
    chk("full eng_valid", e_valid, 4'b0001);
    push(2'd2, 21'd99);
    step();
    c_valid = 1'b0;
    chk("full extra cmd_ready", c_ready, 0);
    for (int j = 0; j < 5; j++) begin
      oh = 4'b0001 << qops[j];
      wait_dispatch($sformatf("full dispatch%0d", j), oh);
      chk($sformatf("full eng_addr_b%0d", j), e_ab, AW'(j));
      e_done = oh;
      step();
      e_done = '0;
      chk($sformatf("full cmp_valid%0d", j), cmp_valid, 1);
      chk($sformatf("full cmp_op%0d", j), cmp_op, qops[j]);
      chk($sformatf("full drain eng_valid%0d", j), e_valid, 0);
      chk($sformatf("full drain busy%0d", j), busy, 1);
      step();
      chk($sformatf("full post cmp_valid%0d", j), cmp_valid, 0);
    end
    chk("full final busy", busy, 0);
    for (int j = 0; j < 4; j++) begin
      step();
      chk($sformatf("full no extra dispatch%0d", j), e_valid, 0);
    end

    // Back-to-back with a push in the done cycle
    push(2'd1, 21'd11);
    step();
    push(2'd2, 21'd22);
    step();
    chk("b2b first eng_valid", e_valid, 4'b0010);
    push(2'd3, 21'd33);
    e_done = 4'b0010;
    step();
    c_valid = 1'b0;
    e_done = '0;
    chk("b2b m cmp_valid", cmp_valid, 1);
    chk("b2b m cmp_op", cmp_op, 1);
    chk("b2b m eng_valid", e_valid, 0);
    step();
    chk("b2b m+1 eng_valid", e_valid, 0);
    step();
    chk("b2b m+2 eng_valid", e_valid, 4'b0100);
    chk("b2b m+2 eng_addr_b", e_ab, 22);
    e_done = 4'b0100;
    step();
    e_done = '0;
    chk("b2b second cmp_op", cmp_op, 2);
    wait_dispatch("b2b pushed dispatch", 4'b1000);
    chk("b2b pushed eng_addr_b", e_ab, 33);
    e_done = 4'b1000;
    step();
    e_done = '0;
    chk("b2b third cmp_valid", cmp_valid, 1);
    chk("b2b third cmp_op", cmp_op, 3);
    step();
    chk("b2b idle busy", busy, 0);

    // Reset while running with two commands queued
    push(2'd0, 21'd1);
    step();
    push(2'd1, 21'd2);
    step();
    push(2'd2, 21'd3);
    step();
    c_valid = 1'b0;
    chk("rstrun eng_valid before", e_valid, 4'b0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstrun eng_valid", e_valid, 0);
    chk("rstrun cmd_ready", c_ready, 1);
    chk("rstrun busy", busy, 0);
    chk("rstrun cmp_valid", cmp_valid, 0);
    step();
    chk("rstrun later busy", busy, 0);
    chk("rstrun later eng_valid", e_valid, 0);
    chk("rstrun later cmp_valid", cmp_valid, 0);
    push(2'd3, 21'd55);
    step();
    c_valid = 1'b0;
    step();
    chk("rstrun new eng_valid", e_valid, 4'b1000);
    chk("rstrun new eng_addr_b", e_ab, 55);
    e_done = 4'b1000;
    step();
    e_done = '0;
    chk("rstrun new cmp_op", cmp_op, 3);
    chk("rstrun new cmp_valid", cmp_valid, 1);
    step();

    // Unmapped opcode on the 3-kernel instance
    d3_valid = 1'b1;
    d3_op = 2'd3;
    step();
    chk("badop e1 err", d3_err, 0);
    d3_op = 2'd0;
    step();
    d3_valid = 1'b0;
    chk("badop e2 err", d3_err, 1);
    chk("badop e2 eng_valid", d3_ev, 0);
    step();
    chk("badop e3 err", d3_err, 0);
    chk("badop e3 eng_valid", d3_ev, 3'b001);
    d3_done = 3'b001;
    step();
    d3_done = '0;
    chk("badop cmp_valid", d3_cmp, 1);
    chk("badop cmp_op", d3_cop, 0);
    step();
    step();
    chk("badop err pulses", 64'(n_d3_err), 1);
    chk("badop cmp pulses", 64'(n_d3_cmp), 1);
    chk("badop busy", d3_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hdc_op_sequencer.md
Name: hdc_op_sequencer

Overview:
- Command scheduler in front of the hypervector operation kernels (element add/cut, bind, permute, ...).
- Buffers queued commands {opcode, addr_a, addr_b, addr_c} and dispatches them one at a time to the selected kernel with a valid/done handshake.
- Owns the single shared dual-port RAM and muxes the active kernel's RAM signals onto it.
- Only one kernel runs at a time, because there is one RAM write port.

Parameters:
- NUM_ENGINES, 4, number of attached kernels; opcode selects the kernel index.
- OP_W, 2, opcode width; NUM_ENGINES <= 2**OP_W.
- FIFO_DEPTH, 4, command queue entries; power of two, >= 2.
- ADDR_W, 21, RAM word address width.
- DATA_W, 32, RAM data width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept (not full)
- cmd_op  in  OP_W  kernel index
- cmd_addr_a  in  ADDR_W  operand A base
- cmd_addr_b  in  ADDR_W  operand B base
- cmd_addr_c  in  ADDR_W  result base
- eng_valid  out  NUM_ENGINES  one-hot start/hold to kernels
- eng_addr_a  out  ADDR_W  broadcast operand A base
- eng_addr_b  out  ADDR_W  broadcast operand B base
- eng_addr_c  out  ADDR_W  broadcast result base
- eng_done  in  NUM_ENGINES  kernel completion
- eng_we_n  in  NUM_ENGINES  per-kernel RAM write enable, active low
- eng_waddress  in  NUM_ENGINES*ADDR_W  per-kernel write address
- eng_data_wr  in  NUM_ENGINES*DATA_W  per-kernel write data
- eng_raddress  in  NUM_ENGINES*ADDR_W  per-kernel read address
- ram_we_n  out  1  to RAM
- ram_waddress  out  ADDR_W  to RAM
- ram_data_wr  out  DATA_W  to RAM
- ram_raddress  out  ADDR_W  to RAM
- busy  out  1  state != IDLE or queue non-empty
- cmp_valid  out  1  one-cycle completion pulse
- cmp_op  out  OP_W  opcode of the completed command
- err_badop  out  1  one-cycle pulse when a command with opcode >= NUM_ENGINES is dropped

Behaviour:
- Reset values (synchronous):
  - FIFO empty, state IDLE, cmd_ready=1.
  - eng_valid=0, eng_addr_*=0, cmp_valid=0, cmp_op=0, err_badop=0, busy=0.
  - ram_we_n=1, ram_waddress=0, ram_raddress=0, ram_data_wr=0.
- Reset mid-operation: the queue is flushed, eng_valid drops on the next cycle, and the in-flight command is discarded with no cmp_valid.
- FIFO:
  - Push on cmd_valid&&cmd_ready. cmd_ready = !full, combinational from the count.
  - cmd_valid while full: ignored, no overwrite.
  - Push and pop in the same cycle: both occur, count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, RUN, DRAIN.
- IDLE, FIFO non-empty:
  - Pop the head into cur_op/cur_a/cur_b/cur_c.
  - If head op < NUM_ENGINES: go to RUN.
  - Otherwise: pulse err_badop next cycle and stay IDLE.
  - A command accepted at edge k therefore raises eng_valid in cycle k+1.
- RUN:
  - eng_valid[cur_op]=1 and held level-high; eng_addr_* = cur registers.
  - RAM mux selects kernel cur_op.
  - On eng_done[cur_op]=1: go to DRAIN.
  - eng_done from non-selected kernels is ignored.
- DRAIN (exactly 1 cycle):
  - eng_valid=0, so the kernel sees valid low and clears done.
  - cmp_valid=1, cmp_op=cur_op.
  - RAM mux is idle; go to IDLE.
- Throughput: back-to-back commands have a 2-cycle gap between done sampled and the next eng_valid (DRAIN, then IDLE pop).
- RAM mux: combinational from registered state/cur_op. Outside RUN, ram_we_n=1 and addresses/data are 0. Idle-kernel RAM outputs never reach the RAM.
- Done in the same cycle as a push: both are honoured.
- eng_done held high into IDLE: ignored.
- No timeout; a hung kernel holds RUN until reset.

Decomposition:
- Package hdc_seq_pkg:
  - typedef state_t {IDLE, RUN, DRAIN}
  - typedef cmd_t packed struct {op, addr_a, addr_b, addr_c}
  - ADDR_W/DATA_W defaults
- Sub-module hdc_cmd_fifo: synchronous FIFO of cmd_t, FIFO_DEPTH entries, with full/empty/count.
- FSM and RAM mux stay in the top.

Test Plan:
- Single command: push {op=1, a=0, b=1024, c=2048} at edge k.
  - eng_valid=4'b0010 from cycle k+1, eng_addr_b=1024.
  - Kernel 1 writes we_n=0, waddress=2048, data=50 → the same values appear on ram_*.
  - done after 10 cycles → cmp_valid=1 with cmp_op=1 for one cycle; eng_valid=0 in that cycle.
- Queue full: push 5 commands with no done.
  - The 1st pops into RUN, so 4 more are queued (count=4) and cmd_ready=0.
  - A further push is ignored.
  - Complete all 5 → cmp_op order 0,1,2,3,0 matches push order; busy drops after the last cmp_valid.
- Bad opcode: NUM_ENGINES=3, push op=3 then op=0.
  - err_badop pulses once, no eng_valid for op 3.
  - Op 0 dispatches next; no cmp_valid for the dropped command.
- Isolation: while kernel 2 runs, kernel 0 drives we_n=0, waddress=5 and asserts done.
  - ram_we_n follows kernel 2 only; the FSM stays in RUN.
- Reset mid-RUN: assert reset for 1 cycle during RUN with 2 commands queued.
  - Next cycle: eng_valid=0, cmd_ready=1, busy=0, no cmp_valid.
  - A new push dispatches normally.
- Back-to-back: two queued commands.
  - done sampled at edge m → cmp_valid in cycle m, next eng_valid in cycle m+2.
  - Simultaneous push at edge m is accepted.
